// File: rtl/cfg_pkg.sv
// Shared state encoding, CRC constant and parameter defaults for the scan loader.
// The VERIFY encoding only exists when CFG_READBACK_EN is defined.
package cfg_pkg;

    localparam int CHAIN_LEN_DEF = 16;
    localparam int WORD_W_DEF    = 8;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_WORD = 3'd1,
        SHIFT     = 3'd2,
`ifdef CFG_READBACK_EN
        VERIFY    = 3'd3,
`endif
        DONE      = 3'd4
    } cfg_state_e;

    // One serial CRC-8 step, MSB-first, feedback taken from the top bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator; only present when CFG_READBACK_EN is defined,
// because nothing else in the design uses it.
`ifdef CFG_READBACK_EN
module crc8_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic       din,
    output logic [7:0] crc
);
    import cfg_pkg::*;

    // CRC register: clear has priority over accumulating a new bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (clear) begin
            crc <= 8'h00;
        end else if (enable) begin
            crc <= crc8_step(crc, din);
        end else begin
            crc <= crc;
        end
    end

endmodule
`endif

// File: rtl/cfg_scan_loader.sv
// Loads host words serially, MSB first, into a configuration scan chain.
// CFG_READBACK_EN adds a recirculating VERIFY pass with CRC-8 compare.
module cfg_scan_loader #(
    parameter int CHAIN_LEN = cfg_pkg::CHAIN_LEN_DEF,
    parameter int WORD_W    = cfg_pkg::WORD_W_DEF
) (
    input  logic              scan_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              scan_en,
    output logic              scan_in,
    input  logic              scan_ret,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import cfg_pkg::*;

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int BW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] CHAIN_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [BW-1:0] WORD_LAST  = BW'(WORD_W - 1);

    cfg_state_e        state_r, next_state_s;
    logic [WORD_W-1:0] word_r;
    logic [CW-1:0]     bit_cnt_r;
    logic [BW-1:0]     word_bits_r;
    logic              in_ready_r, scan_en_r, busy_r, done_r;
    logic              start_ok_s, hs_s, chain_end_s, word_end_s, verify_next_s;

    assign start_ok_s  = (state_r == IDLE) && start && !abort;
    assign hs_s        = (state_r == WAIT_WORD) && in_valid;
    assign chain_end_s = (bit_cnt_r == CHAIN_LAST);
    // A short final word ends early at the chain length; its low bits are dropped.
    assign word_end_s  = (word_bits_r == WORD_LAST) || chain_end_s;

    // Next-state decode; abort overrides every transition
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) next_state_s = WAIT_WORD;
                    else       next_state_s = IDLE;
                end
                WAIT_WORD: begin
                    if (in_valid) next_state_s = SHIFT;
                    else          next_state_s = WAIT_WORD;
                end
                SHIFT: begin
                    if (chain_end_s) begin
`ifdef CFG_READBACK_EN
                        next_state_s = VERIFY;
`else
                        next_state_s = DONE;
`endif
                    end else if (word_end_s) begin
                        next_state_s = WAIT_WORD;
                    end else begin
                        next_state_s = SHIFT;
                    end
                end
`ifdef CFG_READBACK_EN
                VERIFY: begin
                    if (chain_end_s) next_state_s = DONE;
                    else             next_state_s = VERIFY;
                end
`endif
                DONE:    next_state_s = IDLE;
                default: next_state_s = IDLE;
            endcase
        end
    end

`ifdef CFG_READBACK_EN
    assign verify_next_s = (next_state_s == VERIFY);
`else
    assign verify_next_s = 1'b0;
`endif

    // State register plus outputs registered from the next state
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            scan_en_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == WAIT_WORD);
            scan_en_r  <= (next_state_s == SHIFT) || verify_next_s;
            busy_r     <= (next_state_s != IDLE) && (next_state_s != DONE);
            done_r     <= (next_state_s == DONE);
        end
    end

    // Word shifter and bit counters; the word is zeroed when it is used up
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r      <= '0;
            bit_cnt_r   <= '0;
            word_bits_r <= '0;
        end else if (abort) begin
            word_r      <= '0;
            bit_cnt_r   <= bit_cnt_r;
            word_bits_r <= word_bits_r;
        end else if (start_ok_s) begin
            word_r      <= '0;
            bit_cnt_r   <= '0;
            word_bits_r <= '0;
        end else if (hs_s) begin
            word_r      <= in_data;
            bit_cnt_r   <= bit_cnt_r;
            word_bits_r <= '0;
        end else if (state_r == SHIFT) begin
            word_r      <= word_end_s ? '0 : (word_r << 1'b1);
            word_bits_r <= word_bits_r + BW'(1);
`ifdef CFG_READBACK_EN
            bit_cnt_r   <= chain_end_s ? '0 : (bit_cnt_r + CW'(1));
`else
            bit_cnt_r   <= bit_cnt_r + CW'(1);
`endif
`ifdef CFG_READBACK_EN
        end else if (state_r == VERIFY) begin
            word_r      <= word_r;
            bit_cnt_r   <= bit_cnt_r + CW'(1);
            word_bits_r <= word_bits_r;
`endif
        end else begin
            word_r      <= word_r;
            bit_cnt_r   <= bit_cnt_r;
            word_bits_r <= word_bits_r;
        end
    end

    assign in_ready = in_ready_r;
    assign scan_en  = scan_en_r;
    assign busy     = busy_r;
    assign done     = done_r;

`ifdef CFG_READBACK_EN
    logic       verify_r, err_r, mismatch_s;
    logic [7:0] load_crc_s, rb_crc_s;

    // Marks the recirculation pass, where the chain tail feeds back to its head
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) verify_r <= 1'b0;
        else        verify_r <= verify_next_s;
    end

    assign scan_in = verify_r ? scan_ret : word_r[WORD_W-1];

    crc8_serial u_load_crc (
        .clk    (scan_clk),
        .rst_n  (rst_n),
        .enable (state_r == SHIFT),
        .clear  (start_ok_s),
        .din    (scan_in),
        .crc    (load_crc_s)
    );

    crc8_serial u_rb_crc (
        .clk    (scan_clk),
        .rst_n  (rst_n),
        .enable (state_r == VERIFY),
        .clear  (start_ok_s),
        .din    (scan_ret),
        .crc    (rb_crc_s)
    );

    // The last readback bit is folded in here so err is valid in the DONE cycle.
    assign mismatch_s = (crc8_step(rb_crc_s, scan_ret) != load_crc_s);

    // Sticky error flag, cleared only by an accepted start
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (start_ok_s) begin
            err_r <= 1'b0;
        end else if ((state_r == VERIFY) && chain_end_s && !abort) begin
            err_r <= err_r | mismatch_s;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    logic unused_scan_ret_s;
    assign unused_scan_ret_s = scan_ret;
    assign scan_in = word_r[WORD_W-1];
    assign err     = 1'b0;
`endif

endmodule
